// File: rtl/fp_pkg.sv
// Shared floating-point definitions: field widths, significand bit positions,
// FSM encoding and packed special values used by the FPU datapath stages.
package fp_pkg;

    localparam int EXP_W    = 8;
    localparam int FRAC_W   = 23;
    localparam int MANT_W   = FRAC_W + 5;
    localparam int XEXP_W   = EXP_W + 2;
    localparam int EXP_BIAS = 127;
    localparam int EXP_MAX  = 255;

    // Significand layout: ovf | hidden | fraction | G | R | S
    localparam int BIT_OVF = MANT_W - 1;
    localparam int BIT_HID = MANT_W - 2;
    localparam int BIT_LSB = 3;
    localparam int BIT_G   = 2;
    localparam int BIT_R   = 1;
    localparam int BIT_S   = 0;

    localparam logic [31:0] POS_INF = 32'h7F80_0000;
    localparam logic [31:0] NEG_INF = 32'hFF80_0000;
    localparam logic [31:0] ZERO    = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_SHIFT,
        ST_ROUND,
        ST_RENORM,
        ST_PACK
    } state_t;

    typedef logic signed [XEXP_W-1:0] xexp_t;

endpackage

// File: rtl/arredonda_rne.sv
// Round-to-nearest-even on a hidden.fraction.GRS significand; returns the
// rounded hidden+fraction and the carry out of the hidden bit.
module arredonda_rne
    import fp_pkg::*;
(
    input  logic [MANT_W-2:0] i_mant,
    output logic [FRAC_W:0]   o_sig,
    output logic              o_carry
);

    logic              w_inc;
    logic [FRAC_W+1:0] w_sum;

    assign w_inc   = i_mant[BIT_G] & (i_mant[BIT_R] | i_mant[BIT_S] | i_mant[BIT_LSB]);
    assign w_sum   = {1'b0, i_mant[BIT_HID:BIT_LSB]} + {{(FRAC_W+1){1'b0}}, w_inc};
    assign o_sig   = w_sum[FRAC_W:0];
    assign o_carry = w_sum[FRAC_W+1];

endmodule

// File: rtl/fp_normaliza_arredonda.sv
// Post-ALU stage: normalizes the raw significand, rounds RNE, detects
// over/underflow and packs an IEEE-754 single-precision result.
module fp_normaliza_arredonda
    import fp_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              sinal,
    input  logic [EXP_W-1:0]  exp_in,
    input  logic [MANT_W-1:0] mant_in,
    output logic [31:0]       s,
    output logic              finish,
    output logic              busy,
    output logic              overflow,
    output logic              underflow,
    output state_t            dbg_state
);

    state_t            r_state, w_state_nxt;
    logic              r_sign, w_sign_nxt;
    xexp_t             r_exp, w_exp_nxt, w_exp_dec, w_exp_inc;
    logic [MANT_W-1:0] r_mant, w_mant_nxt, w_mant_shl, w_mant_shr;
    logic              r_zero, w_zero_nxt;
    logic [31:0]       r_s, w_s_pack;
    logic              r_ovf, r_unf, w_ovf_pack, w_unf_pack;
    logic [FRAC_W:0]   w_sig_rnd;
    logic              w_carry_rnd;

    arredonda_rne u_rne (
        .i_mant  (r_mant[MANT_W-2:0]),
        .o_sig   (w_sig_rnd),
        .o_carry (w_carry_rnd)
    );

    assign w_exp_dec  = r_exp - xexp_t'(1);
    assign w_exp_inc  = r_exp + xexp_t'(1);
    assign w_mant_shl = r_mant << 1;
    // The bit pushed out on a right shift must survive as sticky.
    assign w_mant_shr = {1'b0, r_mant[MANT_W-1:2], r_mant[1] | r_mant[0]};

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sign_nxt  = r_sign;
        w_exp_nxt   = r_exp;
        w_mant_nxt  = r_mant;
        w_zero_nxt  = r_zero;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_sign_nxt  = sinal;
                    w_exp_nxt   = xexp_t'({2'b00, exp_in});
                    w_mant_nxt  = mant_in;
                    w_zero_nxt  = 1'b0;
                    w_state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (r_mant == '0) begin
                    w_zero_nxt  = 1'b1;
                    w_state_nxt = ST_PACK;
                end else if (r_mant[BIT_OVF]) begin
                    w_mant_nxt  = w_mant_shr;
                    w_exp_nxt   = w_exp_inc;
                    w_state_nxt = ST_ROUND;
                end else if (r_mant[BIT_HID]) begin
                    w_state_nxt = ST_ROUND;
                end else begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_exp_nxt = w_exp_dec;
                if (w_exp_dec <= xexp_t'(0)) begin
                    w_mant_nxt  = '0;
                    w_state_nxt = ST_PACK;
                end else begin
                    w_mant_nxt = w_mant_shl;
                    if (w_mant_shl[BIT_HID]) w_state_nxt = ST_ROUND;
                end
            end
            ST_ROUND: begin
                w_mant_nxt  = {w_carry_rnd, w_sig_rnd, 3'b000};
                w_state_nxt = w_carry_rnd ? ST_RENORM : ST_PACK;
            end
            ST_RENORM: begin
                w_mant_nxt  = w_mant_shr;
                w_exp_nxt   = w_exp_inc;
                w_state_nxt = ST_PACK;
            end
            ST_PACK: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Packed from next-cycle values so s is already valid while finish is high.
    always_comb begin
        w_s_pack   = {w_sign_nxt, w_exp_nxt[EXP_W-1:0], w_mant_nxt[BIT_HID-1:BIT_LSB]};
        w_ovf_pack = 1'b0;
        w_unf_pack = 1'b0;
        if (w_zero_nxt) begin
            w_s_pack = {w_sign_nxt, ZERO[30:0]};
        end else if (w_exp_nxt >= xexp_t'(EXP_MAX)) begin
            w_s_pack   = w_sign_nxt ? NEG_INF : POS_INF;
            w_ovf_pack = 1'b1;
        end else if (w_exp_nxt <= xexp_t'(0)) begin
            w_s_pack   = {w_sign_nxt, ZERO[30:0]};
            w_unf_pack = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sign <= 1'b0;
            r_exp  <= '0;
            r_mant <= '0;
            r_zero <= 1'b0;
            r_s    <= '0;
            r_ovf  <= 1'b0;
            r_unf  <= 1'b0;
        end else begin
            r_sign <= w_sign_nxt;
            r_exp  <= w_exp_nxt;
            r_mant <= w_mant_nxt;
            r_zero <= w_zero_nxt;
            if (r_state == ST_IDLE && start) begin
                r_ovf <= 1'b0;
                r_unf <= 1'b0;
            end else if (w_state_nxt == ST_PACK) begin
                r_s   <= w_s_pack;
                r_ovf <= w_ovf_pack;
                r_unf <= w_unf_pack;
            end
        end
    end

    always_comb begin
        busy   = (r_state != ST_IDLE);
        finish = (r_state == ST_PACK);
    end

    assign s         = r_s;
    assign overflow  = r_ovf;
    assign underflow = r_unf;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_fp_normaliza_arredonda.sv
// Directed bench for the normalize/round/pack stage with a scoreboard of
// expected packed words, flags and latencies.
module tb_fp_normaliza_arredonda;
    import fp_pkg::*;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              sinal = 1'b0;
    logic [EXP_W-1:0]  exp_in = '0;
    logic [MANT_W-1:0] mant_in = '0;
    logic [31:0]       s;
    logic              finish, busy, overflow, underflow;
    state_t            dbg_state;

    logic [33:0] exp_q[$];
    int          lat_q[$];
    int          pass_cnt = 0;
    int          total_cnt = 0;
    logic [31:0] last_s = '0;

    fp_normaliza_arredonda dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .sinal     (sinal),
        .exp_in    (exp_in),
        .mant_in   (mant_in),
        .s         (s),
        .finish    (finish),
        .busy      (busy),
        .overflow  (overflow),
        .underflow (underflow),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // poke_mid raises start with junk data during the operation;
    // poke_fin raises start in the cycle finish is high.
    task automatic run_op(input string tag, input logic sg, input logic [7:0] e,
                          input logic [27:0] m, input logic [31:0] xs, input logic xo,
                          input logic xu, input int xlat, input bit poke_mid, input bit poke_fin);
        int          lat;
        bit          done;
        int          busy_drops;
        logic [33:0] item;
        int          exp_lat;
        exp_q.push_back({xo, xu, xs});
        lat_q.push_back(xlat);
        sinal = sg; exp_in = e; mant_in = m; start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_flags_clr"}, {30'd0, overflow, underflow}, 32'd0);
        check({tag, "_s_hold"}, s, last_s);
        lat = 1; done = 1'b0; busy_drops = 0;
        while (!done && lat < 40) begin
            if (!busy) busy_drops++;
            if (finish) done = 1'b1;
            else begin
                if (poke_mid && lat == 2) begin
                    start = 1'b1; sinal = 1'b1; exp_in = 8'h05; mant_in = 28'h0000001;
                end else start = 1'b0;
                tick();
                lat++;
            end
        end
        start = 1'b0;
        check({tag, "_finish_seen"}, {31'd0, done}, 32'd1);
        check({tag, "_busy_thru"}, 32'(busy_drops), 32'd0);
        item = exp_q.pop_front();
        exp_lat = lat_q.pop_front();
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_s"}, s, item[31:0]);
        check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, item[33]});
        check({tag, "_unf"}, {31'd0, underflow}, {31'd0, item[32]});
        last_s = item[31:0];
        if (poke_fin) begin
            start = 1'b1; sinal = 1'b1; exp_in = 8'h10; mant_in = 28'h4000000;
        end
        tick();
        start = 1'b0;
        check({tag, "_finish_pulse"}, {31'd0, finish}, 32'd0);
        check({tag, "_idle_after"}, {31'd0, busy}, 32'd0);
        check({tag, "_s_after"}, s, last_s);
    endtask

    initial begin
        int fin_cnt;
        reset = 1'b1;
        repeat (3) tick();
        check("rst_s", s, 32'd0);
        check("rst_finish", {31'd0, finish}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_flags", {30'd0, overflow, underflow}, 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        reset = 1'b0;
        tick();

        run_op("t1_1p5", 1'b0, 8'd127, 28'h6000000, 32'h3FC00000, 1'b0, 1'b0, 3, 1'b0, 1'b0);
        run_op("t1_neg", 1'b1, 8'd127, 28'h6000000, 32'hBFC00000, 1'b0, 1'b0, 3, 1'b0, 1'b0);
        run_op("t2_carry", 1'b0, 8'd127, 28'h8000000, 32'h40000000, 1'b0, 1'b0, 3, 1'b0, 1'b0);
        run_op("t3_lshift", 1'b0, 8'd127, 28'h1000000, 32'h3E800000, 1'b0, 1'b0, 5, 1'b1, 1'b0);
        run_op("t4_renorm", 1'b0, 8'd127, 28'h7FFFFFC, 32'h40000000, 1'b0, 1'b0, 4, 1'b0, 1'b0);
        run_op("rne_tie_even", 1'b0, 8'd127, 28'h4000004, 32'h3F800000, 1'b0, 1'b0, 3, 1'b0, 1'b0);
        run_op("rne_tie_odd", 1'b0, 8'd127, 28'h400000C, 32'h3F800002, 1'b0, 1'b0, 3, 1'b0, 1'b0);
        run_op("rne_sticky", 1'b0, 8'd127, 28'h4000005, 32'h3F800001, 1'b0, 1'b0, 3, 1'b0, 1'b0);
        run_op("t5_ovf", 1'b0, 8'd254, 28'h8000000, 32'h7F800000, 1'b1, 1'b0, 3, 1'b0, 1'b1);
        run_op("t5_zero", 1'b1, 8'd127, 28'h0000000, 32'h80000000, 1'b0, 1'b0, 2, 1'b0, 1'b0);
        run_op("unf_flush", 1'b1, 8'd2, 28'h0800000, 32'h80000000, 1'b0, 1'b1, 4, 1'b0, 1'b0);
        run_op("ovf_neg", 1'b1, 8'd254, 28'h8000000, 32'hFF800000, 1'b1, 1'b0, 3, 1'b0, 1'b0);
        run_op("one", 1'b0, 8'(EXP_BIAS), 28'h4000000, 32'h3F800000, 1'b0, 1'b0, 3, 1'b0, 1'b0);

        // Abort an operation with reset during its second left-shift cycle.
        sinal = 1'b0; exp_in = 8'd127; mant_in = 28'h1000000; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("t6_in_shift", 32'(dbg_state), 32'(ST_SHIFT));
        reset = 1'b1;
        tick();
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_s", s, 32'd0);
        check("t6_finish", {31'd0, finish}, 32'd0);
        check("t6_state", 32'(dbg_state), 32'(ST_IDLE));
        reset = 1'b0;
        fin_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (finish) fin_cnt++;
        end
        check("t6_no_finish", 32'(fin_cnt), 32'd0);
        last_s = 32'd0;
        run_op("t6_after", 1'b0, 8'd127, 28'h6000000, 32'h3FC00000, 1'b0, 1'b0, 3, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
